// File: rtl/archev_mem_pkg.sv
// Shared types and helpers for the ArcheV MEM-stage access controller.
// Holds state/width encodings, byte-enable constants and store-lane helpers.
package archev_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } width_e;

    localparam logic [3:0] BE_ALL = 4'b1111;
    localparam logic [3:0] BE_LO  = 4'b0011;
    localparam logic [3:0] BE_HI  = 4'b1100;

    function automatic logic is_misaligned(input width_e w, input logic [1:0] a);
        logic r;
        case (w)
            HALF:    r = a[0];
            WORD:    r = (a != 2'b00);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] store_be(input width_e w, input logic [1:0] a);
        logic [3:0] r;
        case (w)
            WORD:    r = BE_ALL;
            HALF:    r = a[1] ? BE_HI : BE_LO;
            default: r = 4'b0001 << a;
        endcase
        return r;
    endfunction

    // Replicate the store operand across every lane it could land in.
    function automatic logic [31:0] store_wdata(input width_e w, input logic [31:0] d);
        logic [31:0] r;
        case (w)
            WORD:    r = d;
            HALF:    r = {2{d[15:0]}};
            default: r = {4{d[7:0]}};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load-result formatter: selects the addressed byte/half of a
// memory word and sign- or zero-extends it to 32 bits.
module load_formatter
    import archev_mem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  width_e      i_width,
    input  logic        i_signed,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_data = i_rdata;
        case (i_width)
            BYTE:    o_data = {{24{i_signed & w_byte[7]}}, w_byte};
            HALF:    o_data = {{16{i_signed & w_half[15]}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: IDLE -> ACCESS (req until ack or timeout)
// -> DONE (one-cycle release), stalling the pipeline for the access.
module mem_access_ctrl
    import archev_mem_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_in,
    input  logic [31:0] rs2_data_in,
    input  logic        str_en_in,
    input  logic        load_en_in,
    input  logic        sb_en_in,
    input  logic        sh_en_in,
    input  logic        sw_en_in,
    input  logic        lb_en_in,
    input  logic        lh_en_in,
    input  logic        lw_en_in,
    input  logic        lbu_en_in,
    input  logic        lhu_en_in,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    output logic [31:0] load_data_out,
    output logic        load_valid_out,
    output logic        misalign_out,
    output logic        timeout_out,
    output logic [1:0]  dbg_state_out
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    // dmem handshake: dmem_req stays high with address/data/enables frozen
    // until the first cycle dmem_ack is sampled high while in ACCESS; that
    // cycle completes the transfer. dmem_ack in any other state is ignored.

    state_e           r_state;
    state_e           w_next_state;
    logic [29:0]      r_addr_word;
    logic [1:0]       r_addr_lo;
    logic             r_we;
    logic [3:0]       r_be;
    logic [31:0]      r_wdata;
    width_e           r_width;
    logic             r_signed;
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;
    logic [31:0]      r_load_data;

    logic             w_acc;
    logic             w_is_store;
    width_e           w_st_width;
    width_e           w_ld_width;
    width_e           w_width;
    logic             w_ld_signed;
    logic             w_misalign;
    logic [31:0]      w_fmt_data;

    // A store wins when both enables are raised; unsigned wins on conflict.
    always_comb begin
        w_acc      = str_en_in | load_en_in;
        w_is_store = str_en_in;
        w_st_width = sw_en_in ? WORD : (sh_en_in ? HALF : (sb_en_in ? BYTE : BYTE));
        w_ld_width = lw_en_in ? WORD : ((lh_en_in | lhu_en_in) ? HALF : BYTE);
        if (lw_en_in) begin
            w_ld_signed = 1'b0;
        end else if (lh_en_in | lhu_en_in) begin
            w_ld_signed = lh_en_in & ~lhu_en_in;
        end else begin
            w_ld_signed = lb_en_in & ~lbu_en_in;
        end
        w_width    = w_is_store ? w_st_width : w_ld_width;
        w_misalign = is_misaligned(w_width, alu_in[1:0]);
    end

    load_formatter u_load_formatter (
        .i_rdata   (dmem_rdata),
        .i_addr_lo (r_addr_lo),
        .i_width   (r_width),
        .i_signed  (r_signed),
        .o_data    (w_fmt_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr_word <= '0;
            r_addr_lo   <= '0;
            r_we        <= 1'b0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_width     <= BYTE;
            r_signed    <= 1'b0;
            r_cnt       <= '0;
            r_timeout   <= 1'b0;
            r_load_data <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    r_cnt     <= '0;
                    r_timeout <= 1'b0;
                    if (w_acc && !w_misalign) begin
                        r_addr_word <= alu_in[31:2];
                        r_addr_lo   <= alu_in[1:0];
                        r_we        <= w_is_store;
                        r_width     <= w_width;
                        r_signed    <= w_is_store ? 1'b0 : w_ld_signed;
                        r_be        <= w_is_store ? store_be(w_width, alu_in[1:0]) : BE_ALL;
                        r_wdata     <= w_is_store ? store_wdata(w_width, rs2_data_in) : '0;
                    end
                end
                ACCESS: begin
                    if (dmem_ack) begin
                        if (!r_we) begin
                            r_load_data <= w_fmt_data;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        r_timeout   <= 1'b1;
                        r_load_data <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs are forced low while rst is high, even before the reset edge.
    always_comb begin
        w_next_state   = r_state;
        stall_out      = 1'b0;
        dmem_req       = 1'b0;
        dmem_we        = 1'b0;
        dmem_addr      = '0;
        dmem_wdata     = '0;
        dmem_be        = '0;
        load_valid_out = 1'b0;
        misalign_out   = 1'b0;
        timeout_out    = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        if (w_misalign) begin
                            misalign_out = 1'b1;
                        end else begin
                            stall_out    = 1'b1;
                            w_next_state = ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    stall_out  = 1'b1;
                    dmem_req   = 1'b1;
                    dmem_we    = r_we;
                    dmem_addr  = {r_addr_word, 2'b00};
                    dmem_wdata = r_wdata;
                    dmem_be    = r_be;
                    if (dmem_ack || (r_cnt == CNT_LAST)) begin
                        w_next_state = DONE;
                    end
                end
                DONE: begin
                    load_valid_out = ~r_we & ~r_timeout;
                    timeout_out    = r_timeout;
                    w_next_state   = IDLE;
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
        end
    end

    assign load_data_out = r_load_data;
    assign dbg_state_out = rst ? 2'd0 : r_state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (MAX_WAIT = 4).
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_in, rs2_data_in, dmem_rdata;
  logic        str_en_in, load_en_in;
  logic        sb_en_in, sh_en_in, sw_en_in;
  logic        lb_en_in, lh_en_in, lw_en_in, lbu_en_in, lhu_en_in;
  logic        dmem_ack;
  logic        stall_out, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, load_data_out;
  logic [3:0]  dmem_be;
  logic        load_valid_out, misalign_out, timeout_out;
  logic [1:0]  dbg_state_out;

  int total = 0;
  int bad = 0;

  mem_access_ctrl #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .alu_in(alu_in), .rs2_data_in(rs2_data_in),
    .str_en_in(str_en_in), .load_en_in(load_en_in),
    .sb_en_in(sb_en_in), .sh_en_in(sh_en_in), .sw_en_in(sw_en_in),
    .lb_en_in(lb_en_in), .lh_en_in(lh_en_in), .lw_en_in(lw_en_in),
    .lbu_en_in(lbu_en_in), .lhu_en_in(lhu_en_in),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .load_data_out(load_data_out), .load_valid_out(load_valid_out),
    .misalign_out(misalign_out), .timeout_out(timeout_out),
    .dbg_state_out(dbg_state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alu_in = '0; rs2_data_in = '0;
    str_en_in = 0; load_en_in = 0;
    sb_en_in = 0; sh_en_in = 0; sw_en_in = 0;
    lb_en_in = 0; lh_en_in = 0; lw_en_in = 0; lbu_en_in = 0; lhu_en_in = 0;
  endtask

  // w: 0=sb 1=sh 2=sw
  task automatic set_store(input logic [31:0] a, input logic [31:0] d, input int w);
    clear_inputs();
    str_en_in = 1; alu_in = a; rs2_data_in = d;
    sb_en_in = (w == 0); sh_en_in = (w == 1); sw_en_in = (w == 2);
  endtask

  // k: 0=lb 1=lbu 2=lh 3=lhu 4=lw
  task automatic set_load(input logic [31:0] a, input int k);
    clear_inputs();
    load_en_in = 1; alu_in = a;
    lb_en_in = (k == 0); lbu_en_in = (k == 1); lh_en_in = (k == 2);
    lhu_en_in = (k == 3); lw_en_in = (k == 4);
  endtask

  // Entered in IDLE with the access already on the inputs.
  task automatic run_access(input string tag, input int waits, input logic [31:0] rdata,
                            input logic exp_we, input logic exp_valid,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_data);
    int stalls = 0;
    int reqs = 0;
    #1;
    chk({tag, "_idle_req"}, dmem_req, 0);
    stalls += int'(stall_out);
    tick();
    chk({tag, "_state_acc"}, dbg_state_out, 2'd1);
    chk({tag, "_we"}, dmem_we, exp_we);
    chk({tag, "_addr"}, dmem_addr, exp_addr);
    chk({tag, "_be"}, dmem_be, exp_be);
    chk({tag, "_wdata"}, dmem_wdata, exp_wdata);
    clear_inputs();
    alu_in = 32'hFFFF_FFFF; rs2_data_in = 32'h1357_9BDF;
    for (int i = 0; i < waits; i++) begin
      dmem_ack = 0;
      #1;
      stalls += int'(stall_out);
      reqs += int'(dmem_req);
      tick();
    end
    dmem_ack = 1; dmem_rdata = rdata;
    #1;
    stalls += int'(stall_out);
    reqs += int'(dmem_req);
    chk({tag, "_addr_held"}, dmem_addr, exp_addr);
    tick();
    dmem_ack = 0; dmem_rdata = '0;
    clear_inputs();
    #1;
    chk({tag, "_done_state"}, dbg_state_out, 2'd2);
    chk({tag, "_done_stall"}, stall_out, 0);
    chk({tag, "_done_valid"}, load_valid_out, exp_valid);
    chk({tag, "_done_timeout"}, timeout_out, 0);
    chk({tag, "_load_data"}, load_data_out, exp_data);
    chk({tag, "_stall_cycles"}, stalls, 2 + waits);
    chk({tag, "_req_cycles"}, reqs, 1 + waits);
    tick();
    chk({tag, "_back_idle"}, dbg_state_out, 2'd0);
    chk({tag, "_valid_gone"}, load_valid_out, 0);
    chk({tag, "_data_hold"}, load_data_out, exp_data);
  endtask

  initial begin
    int reqs;
    rst = 1; dmem_ack = 0; dmem_rdata = '0;
    clear_inputs();
    // Reset: outputs stay low even with accesses presented.
    set_load(32'h102, 4);
    tick(); tick();
    chk("rst_misalign", misalign_out, 0);
    set_store(32'h100, 32'hDEADBEEF, 2);
    #1;
    chk("rst_stall", stall_out, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_state", dbg_state_out, 2'd0);
    chk("rst_load_data", load_data_out, 0);
    clear_inputs();
    tick();
    rst = 0;
    #1;
    chk("idle_stall", stall_out, 0);
    chk("idle_req", dmem_req, 0);
    chk("idle_timeout", timeout_out, 0);

    // Stores
    set_store(32'h100, 32'hDEADBEEF, 2);
    #1;
    chk("sw_idle_stall", stall_out, 1);
    run_access("sw", 0, 32'h0, 1, 0, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0);
    set_store(32'h203, 32'h0000_00A5, 0);
    run_access("sb", 0, 32'h0, 1, 0, 32'h200, 4'b1000, 32'hA5A5A5A5, 32'h0);
    set_store(32'h102, 32'h1234_5678, 1);
    run_access("sh", 1, 32'h0, 1, 0, 32'h100, 4'b1100, 32'h5678_5678, 32'h0);

    // Loads
    set_load(32'h301, 0);
    run_access("lb", 3, 32'h1234_80FF, 0, 1, 32'h300, 4'b1111, 32'h0, 32'hFFFF_FF80);
    set_load(32'h301, 1);
    run_access("lbu", 3, 32'h1234_80FF, 0, 1, 32'h300, 4'b1111, 32'h0, 32'h0000_0080);
    set_load(32'h102, 2);
    run_access("lh", 0, 32'h8001_0000, 0, 1, 32'h100, 4'b1111, 32'h0, 32'hFFFF_8001);
    set_load(32'h102, 3);
    run_access("lhu", 1, 32'h8001_0000, 0, 1, 32'h100, 4'b1111, 32'h0, 32'h0000_8001);
    set_load(32'h300, 4);
    run_access("lw", 0, 32'hCAFE_F00D, 0, 1, 32'h300, 4'b1111, 32'h0, 32'hCAFE_F00D);

    // Store and load together: treated as a store, load data untouched.
    set_store(32'h40, 32'h0BAD_F00D, 2);
    load_en_in = 1; lw_en_in = 1;
    run_access("st_ld", 0, 32'h5555_5555, 1, 0, 32'h40, 4'b1111, 32'h0BAD_F00D, 32'hCAFE_F00D);

    // Misaligned accesses never reach memory.
    set_load(32'h102, 4);
    #1;
    chk("lw_mis_flag", misalign_out, 1);
    chk("lw_mis_stall", stall_out, 0);
    chk("lw_mis_req", dmem_req, 0);
    tick();
    chk("lw_mis_state", dbg_state_out, 2'd0);
    chk("lw_mis_req2", dmem_req, 0);
    set_load(32'h103, 2);
    #1;
    chk("lh_mis_flag", misalign_out, 1);
    set_store(32'h101, 32'h0, 1);
    #1;
    chk("sh_mis_flag", misalign_out, 1);
    set_store(32'h103, 32'h0, 0);
    #1;
    chk("sb_odd_ok", misalign_out, 0);
    clear_inputs();
    #1;
    chk("mis_clear", misalign_out, 0);

    // Timeout after MAX_WAIT=4 cycles without ack.
    set_load(32'h500, 4);
    #1;
    chk("to_idle_stall", stall_out, 1);
    tick();
    clear_inputs();
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      if (dbg_state_out != 2'd1) break;
      reqs += int'(dmem_req);
      tick();
    end
    chk("to_req_cycles", reqs, 4);
    chk("to_state_done", dbg_state_out, 2'd2);
    chk("to_pulse", timeout_out, 1);
    chk("to_load_data", load_data_out, 0);
    chk("to_stall", stall_out, 0);
    chk("to_valid", load_valid_out, 0);
    tick();
    chk("to_state_idle", dbg_state_out, 2'd0);
    chk("to_pulse_end", timeout_out, 0);

    // Reset on the second ACCESS cycle.
    set_load(32'h700, 4);
    run_access("lw2", 0, 32'h1111_2222, 0, 1, 32'h700, 4'b1111, 32'h0, 32'h1111_2222);
    set_load(32'h600, 4);
    tick();
    clear_inputs();
    tick();
    chk("rsta_req_before", dmem_req, 1);
    rst = 1;
    #1;
    chk("rsta_req_in_rst", dmem_req, 0);
    chk("rsta_stall_in_rst", stall_out, 0);
    tick();
    rst = 0;
    #1;
    chk("rsta_req", dmem_req, 0);
    chk("rsta_stall", stall_out, 0);
    chk("rsta_state", dbg_state_out, 2'd0);
    chk("rsta_load_data", load_data_out, 0);
    dmem_ack = 1; dmem_rdata = 32'hFFFF_FFFF;
    tick();
    chk("late_ack_valid", load_valid_out, 0);
    chk("late_ack_state", dbg_state_out, 2'd0);
    tick();
    chk("late_ack_valid2", load_valid_out, 0);
    chk("late_ack_data", load_data_out, 0);
    dmem_ack = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
